game_event_sched: RTL and testbench

GAME_EVENT_SCHED -- requirements
Module: game_event_sched

---
 rtl/game_event_sched.sv | 129 ++++++++++++
 tb/tb_game_event_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_event_sched.sv
// game_event_sched: merges user input events (read from a FIFO) with
// gravity ticks generated from a programmable period, presenting one event
// at a time to the game logic over a valid/ready handshake.
module game_event_sched #(
   parameter int TICK_W = 24,
   parameter int OVR_W  = 8
) (
   input  logic              main_logic_clk_i,
   input  logic              rst_n_i,
   input  logic [2:0]        user_event_i,
   input  logic              user_event_ready_i,
   output logic              user_event_rd_req_o,
   input  logic              game_active_i,
   input  logic [TICK_W-1:0] tick_period_i,
   output logic [2:0]        ev_o,
   output logic              ev_valid_o,
   input  logic              ev_ready_i,
   output logic              ev_is_tick_o,
   output logic [OVR_W-1:0]  tick_ovr_cnt_o
);

   localparam logic [2:0]        EV_DOWN  = 3'd3;
   localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};
   localparam logic [OVR_W-1:0]  OVR_ONE  = {{(OVR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      CAP     = 2'd2,
      PRESENT = 2'd3
   } state_t;

   state_t            state;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick_pend;
   logic              last_grant_tick;

   logic              gravity_en;
   logic              tick_wrap;
   logic              grant_user;
   logic              grant_tick;

   // Saturating increment for the overrun counter.
   function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
      return (&v) ? v : v + OVR_ONE;
   endfunction

   // Gravity enable, wrap detection and round-robin arbitration between sources.
   always_comb begin
      gravity_en = game_active_i && (tick_period_i != '0);
      tick_wrap  = gravity_en && (tick_cnt >= (tick_period_i - TICK_ONE));
      grant_user = (state == IDLE) && user_event_ready_i && (!tick_pend || last_grant_tick);
      grant_tick = (state == IDLE) && tick_pend && (!user_event_ready_i || !last_grant_tick);
   end

   // Gravity tick counter, pending flag and overrun counter.
   // A wrap on the same edge that the pending tick is granted counts as a fresh
   // tick, not an overrun, since the old one is being consumed.
   always_ff @(posedge main_logic_clk_i) begin
      if (!rst_n_i) begin
         tick_cnt       <= '0;
         tick_pend      <= 1'b0;
         tick_ovr_cnt_o <= '0;
      end else if (!gravity_en) begin
         tick_cnt  <= '0;
         tick_pend <= 1'b0;
      end else if (tick_wrap) begin
         tick_cnt  <= '0;
         tick_pend <= 1'b1;
         if (tick_pend && !grant_tick) begin
            tick_ovr_cnt_o <= sat_inc(tick_ovr_cnt_o);
         end
      end else begin
         tick_cnt <= tick_cnt + TICK_ONE;
         if (grant_tick) begin
            tick_pend <= 1'b0;
         end
      end
   end

   // Scheduler FSM with registered handshake outputs.
   always_ff @(posedge main_logic_clk_i) begin
      if (!rst_n_i) begin
         state               <= IDLE;
         ev_o                <= '0;
         ev_valid_o          <= 1'b0;
         ev_is_tick_o        <= 1'b0;
         user_event_rd_req_o <= 1'b0;
         last_grant_tick     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant_user) begin
                  state               <= RD;
                  user_event_rd_req_o <= 1'b1;
                  last_grant_tick     <= 1'b0;
               end else if (grant_tick) begin
                  state           <= PRESENT;
                  ev_o            <= EV_DOWN;
                  ev_is_tick_o    <= 1'b1;
                  ev_valid_o      <= 1'b1;
                  last_grant_tick <= 1'b1;
               end
            end
            RD: begin
               user_event_rd_req_o <= 1'b0;
               state               <= CAP;
            end
            CAP: begin
               // FIFO q is valid the cycle after the read request.
               ev_o         <= user_event_i;
               ev_is_tick_o <= 1'b0;
               ev_valid_o   <= 1'b1;
               state        <= PRESENT;
            end
            PRESENT: begin
               if (ev_ready_i) begin
                  ev_valid_o <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_event_sched.sv
// tb_game_event_sched: randomized scoreboard bench for game_event_sched.
// A timing-level reference model predicts each presented event and its
// presentation cycle; a separate monitor pops and compares them.
module tb_game_event_sched;

   localparam int TICK_W  = 24;
   localparam int OVR_W   = 8;
   localparam int OVR_MAX = (1 << OVR_W) - 1;

   localparam logic [2:0] EV_LEFT   = 3'd1;
   localparam logic [2:0] EV_RIGHT  = 3'd2;
   localparam logic [2:0] EV_DOWN   = 3'd3;
   localparam logic [2:0] EV_ROTATE = 3'd4;
   localparam logic [2:0] EV_DROP   = 3'd5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        user_event;
   logic              user_event_ready;
   logic              user_event_rd_req;
   logic              game_active;
   logic [TICK_W-1:0] tick_period;
   logic [2:0]        ev;
   logic              ev_valid;
   logic              ev_ready;
   logic              ev_is_tick;
   logic [OVR_W-1:0]  tick_ovr_cnt;

   game_event_sched #(.TICK_W(TICK_W), .OVR_W(OVR_W)) dut (
      .main_logic_clk_i    (clk),
      .rst_n_i             (rst_n),
      .user_event_i        (user_event),
      .user_event_ready_i  (user_event_ready),
      .user_event_rd_req_o (user_event_rd_req),
      .game_active_i       (game_active),
      .tick_period_i       (tick_period),
      .ev_o                (ev),
      .ev_valid_o          (ev_valid),
      .ev_ready_i          (ev_ready),
      .ev_is_tick_o        (ev_is_tick),
      .tick_ovr_cnt_o      (tick_ovr_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] ev;
      logic       tick;
      int         pres;
   } exp_t;

   exp_t       exp_q[$];
   logic [2:0] fifo_q[$];   // the FIFO the DUT reads
   logic [2:0] mfifo[$];    // model's view of pending user events

   int n_cmp  = 0;
   int n_fail = 0;

   // model state
   int m_cnt       = 0;
   bit m_pend      = 0;
   int m_ovr       = 0;
   bit m_last_tick = 1;
   bit m_busy      = 0;
   int m_pres      = 0;
   int m_free      = 0;
   int m_rd_cyc    = -10;
   bit chk_rst_out = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic push_ev(input logic [2:0] v);
      fifo_q.push_back(v);
      mfifo.push_back(v);
   endtask

   // One cycle: check outputs of the current cycle, service the FIFO, advance the model.
   task automatic step();
      bit   tick_take;
      bit   userp;
      exp_t e;
      exp_t keep[$];
      if (chk_rst_out) begin
         chk("rst_ev_valid", ev_valid, 0);
         chk("rst_ev_o", ev, 0);
         chk("rst_ev_is_tick", ev_is_tick, 0);
         chk("rst_rd_req", user_event_rd_req, 0);
         chk("rst_ovr", tick_ovr_cnt, 0);
         chk_rst_out = 0;
      end
      chk("rd_req", user_event_rd_req, (cyc == m_rd_cyc));
      chk("ovr_cnt", tick_ovr_cnt, m_ovr);
      if (user_event_rd_req === 1'b1 && fifo_q.size() != 0) user_event = fifo_q.pop_front();
      user_event_ready = (fifo_q.size() != 0);
      if (!rst_n) begin
         foreach (exp_q[i]) if (exp_q[i].pres <= cyc) keep.push_back(exp_q[i]);
         exp_q       = keep;
         m_cnt       = 0;
         m_pend      = 0;
         m_ovr       = 0;
         m_last_tick = 1;
         m_busy      = 0;
         m_free      = cyc + 1;
         chk_rst_out = 1;
      end else begin
         tick_take = 0;
         if (m_busy && cyc >= m_pres && ev_ready) begin
            m_busy = 0;
            m_free = cyc + 1;
         end
         if (!m_busy && cyc >= m_free) begin
            userp = (mfifo.size() != 0);
            if (userp && (!m_pend || m_last_tick)) begin
               e.ev = mfifo.pop_front(); e.tick = 0; e.pres = cyc + 3;
               exp_q.push_back(e);
               m_rd_cyc = cyc + 1; m_last_tick = 0; m_busy = 1; m_pres = cyc + 3;
            end else if (m_pend) begin
               e.ev = EV_DOWN; e.tick = 1; e.pres = cyc + 1;
               exp_q.push_back(e);
               tick_take = 1; m_last_tick = 1; m_busy = 1; m_pres = cyc + 1;
            end
         end
         if (!game_active || tick_period == '0) begin
            m_cnt  = 0;
            m_pend = 0;
         end else if (m_cnt >= int'(tick_period) - 1) begin
            m_cnt = 0;
            if (m_pend && !tick_take) m_ovr = (m_ovr == OVR_MAX) ? m_ovr : m_ovr + 1;
            m_pend = 1;
         end else begin
            m_cnt++;
            if (tick_take) m_pend = 0;
         end
      end
      @(negedge clk);
   endtask

   // Monitor: compare each newly presented event against the scoreboard.
   initial begin
      bit         prev_v = 0;
      logic [2:0] h_ev   = '0;
      logic       h_t    = 1'b0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (ev_valid === 1'b1 && !prev_v) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_event @cyc %0d: got ev %0d tick %0d, expected none", cyc, ev, ev_is_tick);
            end else begin
               e = exp_q.pop_front();
               chk("ev_o", ev, e.ev);
               chk("ev_is_tick", ev_is_tick, e.tick);
               chk("ev_present_cycle", cyc, e.pres);
            end
            h_ev = ev;
            h_t  = ev_is_tick;
         end else if (ev_valid === 1'b1) begin
            chk("ev_o_stable", ev, h_ev);
            chk("ev_is_tick_stable", ev_is_tick, h_t);
         end
         prev_v = (ev_valid === 1'b1);
      end
   end

   // Stimulus
   initial begin
      bit seen;
      rst_n = 0; game_active = 0; tick_period = '0; ev_ready = 0;
      user_event = '0; user_event_ready = 0;
      @(negedge clk);
      repeat (3) step();
      rst_n = 1;

      // user event with gravity off
      push_ev(EV_LEFT); ev_ready = 1;
      repeat (10) step();

      // steady gravity, period 10
      game_active = 1; tick_period = 24'd10;
      repeat (45) step();

      // stalled consumer accumulates overruns
      tick_period = 24'd4; ev_ready = 0;
      repeat (20) step();
      ev_ready = 1;
      repeat (10) step();

      // long stall saturates the overrun counter
      tick_period = 24'd1; ev_ready = 0;
      repeat (300) step();
      ev_ready = 1; game_active = 0;
      repeat (6) step();

      // user and tick contending every cycle
      rst_n = 0; step(); rst_n = 1;
      game_active = 1; tick_period = 24'd1; ev_ready = 1;
      repeat (3) push_ev(EV_ROTATE);
      repeat (25) step();

      // period shortened mid-count
      game_active = 0;
      repeat (5) step();
      rst_n = 0; step(); rst_n = 1;
      game_active = 1; tick_period = 24'd100; ev_ready = 1;
      repeat (50) step();
      tick_period = 24'd5;
      repeat (30) step();

      // reset while presenting; remaining FIFO entries still delivered
      game_active = 0; ev_ready = 0;
      repeat (4) step();
      push_ev(EV_LEFT); push_ev(EV_RIGHT); push_ev(EV_DROP);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         seen = (ev_valid === 1'b1);
      end
      chk("present_before_reset", seen, 1);
      repeat (2) step();
      rst_n = 0; step(); rst_n = 1;
      ev_ready = 1;
      repeat (20) step();
      chk("fifo_drained", fifo_q.size(), 0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if (i % 60 == 0) begin
            game_active = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 5))
               0: tick_period = 24'd0;
               1: tick_period = 24'd1;
               2: tick_period = 24'd2;
               3: tick_period = 24'd3;
               4: tick_period = 24'd7;
               default: tick_period = TICK_W'($urandom_range(1, 20));
            endcase
         end
         if ($urandom_range(0, 5) == 0 && fifo_q.size() < 8) push_ev(3'($urandom_range(0, 7)));
         ev_ready = ($urandom_range(0, 9) < 6);
         rst_n    = ($urandom_range(0, 399) != 0);
         step();
      end
      rst_n = 1;

      // drain
      game_active = 0; ev_ready = 1;
      repeat (40) step();
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("final_ev_valid", ev_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
